ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
// - Iterative RV32M multiply/divide unit in the EX stage, in parallel with the ALU.
// - Consumes the operands and rd/op fields held in the ID/EX pipeline register.
// - While an op runs, holds the pipeline through stall_o (IF/ID/EX frozen).
// - Delivers one result to the EX/MEM result mux on completion.
// PARAMETERS
// - XLEN  32  operand/result width; iteration count = XLEN
// PORTS
// - clk           in   1     clock
// - reset         in   1     asynchronous, active-high
// - flush         in   1     sync abort of in-flight op (branch taken in EX)
// - req           in   1     ID/EX holds a valid M-extension instruction (level)
// - op            in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
// - rs1_val       in   XLEN  forwarded operand A (dividend / multiplicand)
// - rs2_val       in   XLEN  forwarded operand B (divisor / multiplier)
// - stall_o       out  1     freeze upstream stages and the ID/EX register
// - busy          out  1     state == BUSY
// - result_valid  out  1     one-cycle pulse; result is valid
// - result        out  XLEN  selected product half / quotient / remainder
// BEHAVIOUR
// - Reset: state=IDLE, count=0, all internal regs 0; result_valid=0, result=0, busy=0.
//   stall_o is combinational (see below), so it equals req while in reset.
// - FSM IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: req=1 at a clock edge latches op, |rs1|, |rs2| (signed ops only; MULHSU takes
//     |rs1| only) and the sign flags; count=0; goes to BUSY.
//   - BUSY: one shift-add (MUL*) or restoring-subtract (DIV/REM*) step per cycle.
//     At count==XLEN-1 -> DONE.
//   - DONE: result registered with sign fix-up; result_valid=1 for exactly this cycle;
//     next state IDLE unconditionally.
// - stall_o = req && (state != DONE) && !flush.
//   - The pipeline advances in DONE, when ID/EX loads the next instruction.
//   - req is ignored in DONE, so the finishing instruction is never restarted.
//   - A back-to-back M op starts from IDLE on the following edge.
// - Latency: the req edge plus XLEN BUSY cycles gives DONE; stall_o is high for XLEN+1
//   cycles (33 at XLEN=32). Latency is fixed for all ops, special cases included.
// - Arithmetic:
//   - 2*XLEN-bit product register. MUL returns the low half; MULH/MULHSU/MULHU return
//     the high half.
//   - Product negated (2*XLEN wide) when sign_a^sign_b applies.
//   - DIV/REM: quotient negated if the signs differ; remainder takes the dividend's sign.
// - Boundary cases, detected at latch time and applied in DONE:
//   - Divisor == 0: DIV/DIVU quotient = all-ones; REM/REMU = rs1_val.
//   - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV = -2^(XLEN-1); REM = 0.
//   - |-2^(XLEN-1)| is computed in XLEN+1 bits; no wrap error.
// - flush: any state -> IDLE next edge; result_valid is suppressed that cycle; result
//   keeps its old value. flush with req in IDLE does not start an op.
// - Reset mid-operation: immediate IDLE; no result_valid is emitted.
// - result holds its last value until the next DONE.
// STRUCTURE
// - muldiv_pkg:
//   - typedef enum logic [2:0] md_op_e (MUL..REMU).
//   - typedef enum logic [1:0] md_state_e {IDLE, BUSY, DONE}.
//   - localparam CNT_W = $clog2(XLEN).
// - Single module. The shared accumulator/shift datapath serves both mul and div;
//   no sub-module is required.
// TESTING
// - MUL 7 * -3 -> result 0xFFFFFFEB at cycle 33 after req; stall_o high for exactly 33 cycles.
// - MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
// - DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 % 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000;
//   REM of the same -> 0.
// - flush at BUSY cycle 10 -> IDLE next edge; no result_valid pulse; a new req then
//   completes normally.
// - Back-to-back MUL then DIV with req held -> two result_valid pulses 34 cycles apart;
//   reset asserted mid-op -> outputs 0, no pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative RV32M multiply/divide unit.
// Op codes follow the funct3 field of the M-extension instructions.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Magnitude taken in XLEN+1 bits so that |-2^(XLEN-1)| does not wrap.
    function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN:0] w;
        w = {v[XLEN-1], v};
        if (neg) begin
            w = -w;
        end
        return w[XLEN-1:0];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide: one shift-add or restoring-subtract step per
// cycle on a shared hi/lo datapath, stalling the front of the pipeline until DONE.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            stall_o,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    md_op_e           op_q, op_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
    logic             sign_a_q, sign_a_d, neg_q, neg_d, div0_q, div0_d, ovf_q, ovf_d;

    md_op_e           req_op;
    logic             signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [XLEN:0]    mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]  step_hi, step_lo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  fix_result;
    logic             last_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
        end
    end

    assign last_step = (count_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Operand decode at latch time: MUL is sign-agnostic in its low half.
    always_comb begin
        req_op   = md_op_e'(op);
        signed_a = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                   (req_op == OP_DIV)  || (req_op == OP_REM);
        signed_b = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        sa       = signed_a && rs1_val[XLEN-1];
        sb       = signed_b && rs2_val[XLEN-1];
        mag_a    = abs_mag(rs1_val, sa);
        mag_b    = abs_mag(rs2_val, sb);
    end

    // One iteration: multiplier bits leave lo from the bottom, quotient bits enter it.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_q) begin
            prod = -prod;
        end
        case (op_q)
            OP_MUL:           fix_result = prod[XLEN-1:0];
            OP_DIV, OP_DIVU: begin
                if (div0_q)     fix_result = '1;
                else if (ovf_q) fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else            fix_result = neg_q ? -step_lo : step_lo;
            end
            OP_REM, OP_REMU: begin
                if (ovf_q)      fix_result = '0;
                else            fix_result = sign_a_q ? -step_hi : step_hi;
            end
            default:          fix_result = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        count_d  = count_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE && req && !flush) begin
            count_d  = '0;
            op_d     = req_op;
            hi_d     = '0;
            lo_d     = op[2] ? mag_a : mag_b;
            b_d      = op[2] ? mag_b : mag_a;
            sign_a_d = sa;
            neg_d    = sa ^ sb;
            div0_d   = (rs2_val == '0);
            ovf_d    = signed_b && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        end else if (state_q == BUSY && !flush) begin
            count_d = count_q + 1'b1;
            hi_d    = step_hi;
            lo_d    = step_lo;
            if (last_step) begin
                result_d = fix_result;
            end
        end
    end

    always_comb begin
        busy         = (state_q == BUSY);
        result_valid = (state_q == DONE) && !flush;
        stall_o      = req && (state_q != DONE) && !flush;
        result       = result_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, randomized ops against a 64-bit
// arithmetic reference, plus flush, back-to-back and mid-op reset sequences.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, req;
    logic [2:0]  op;
    logic [31:0] rs1_val, rs2_val;
    logic        stall_o, busy, result_valid;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    ex_muldiv_unit dut (
        .clk(clk), .reset(reset), .flush(flush), .req(req), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .stall_o(stall_o), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok %s: 0x%08h", name, act);
        end
    endtask

    // Reference computed from the RV32M definitions with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0]        up;
        int                 ia, ib, iq;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'h0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                iq = ia / ib;
                return iq;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                iq = ia % ib;
                return iq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Entered #1 after a posedge with the unit idle; returns #1 after the edge leaving DONE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cycles, output int stalls,
                          output logic done_stall);
        req = 1'b1; op = f; rs1_val = a; rs2_val = b;
        cycles = 0; stalls = 0; res = 'x; done_stall = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            @(posedge clk); #1;
            cycles++;
            if (result_valid) begin
                res = result;
                done_stall = stall_o;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs[12];
        logic [31:0] res, last_res, exp;
        int          cycles, stalls, pulses, t1, t2;
        logic        dstall;

        vecs[0]  = '{"MUL 7*-3",          3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"MULH min*min",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{"MULHU max*max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{"MULHSU -1*max",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{"DIV -7/2",          3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{"REM -7%2",          3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{"DIVU 100/7",        3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{"REMU 100%7",        3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{"DIVU 5/0",          3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{"REM 5%0",           3'd6, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{"DIV ovf",           3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{"REM ovf",           3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};

        reset = 1'b1; flush = 1'b0; req = 1'b0; op = 3'd0; rs1_val = '0; rs2_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset valid", {31'b0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", {31'b0, stall_o}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, cycles, stalls, dstall);
            check(vecs[i].name, res, vecs[i].exp);
            check({vecs[i].name, " latency"}, cycles, 32'd33);
            check({vecs[i].name, " stall cycles"}, stalls, 32'd33);
            check({vecs[i].name, " stall in DONE"}, {31'b0, dstall}, 32'd0);
            last_res = vecs[i].exp;
        end

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(f, a, b, res, cycles, stalls, dstall);
            $display("[TB] rand op=%0d a=0x%08h b=0x%08h", f, a, b);
            check("random result", res, ref_model(f, a, b));
            check("random latency", cycles, 32'd33);
            last_res = ref_model(f, a, b);
        end

        // flush during BUSY cycle 10
        req = 1'b1; op = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        check("flush pre busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush stall low", {31'b0, stall_o}, 32'd0);
        check("flush valid low", {31'b0, result_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req = 1'b0;
        check("flush -> idle", {31'b0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_valid) pulses++;
        end
        check("flush no pulse", pulses, 32'd0);
        check("flush result held", result, last_res);
        run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, res, cycles, stalls, dstall);
        check("after flush", res, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));

        // back-to-back MUL then DIV with req held
        req = 1'b1; op = 3'd0; rs1_val = 32'd123; rs2_val = 32'd456;
        t1 = -1; t2 = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                if (t1 < 0) begin
                    t1 = i;
                    check("b2b MUL", result, ref_model(3'd0, 32'd123, 32'd456));
                    op = 3'd4; rs1_val = 32'hFFFF_FC18; rs2_val = 32'd7;
                end else begin
                    t2 = i;
                    check("b2b DIV", result, ref_model(3'd4, 32'hFFFF_FC18, 32'd7));
                    break;
                end
            end
        end
        req = 1'b0;
        check("b2b pulse gap", t2 - t1, 32'd34);
        @(posedge clk); #1;

        // reset asserted mid-operation
        req = 1'b1; op = 3'd1; rs1_val = 32'h7654_3210; rs2_val = 32'h0FED_CBA9;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst valid", {31'b0, result_valid}, 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst stall==req", {31'b0, stall_o}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_valid) pulses++;
        end
        check("midrst no pulse", pulses, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
